regfile_wordline_ctrl: RTL and testbench



---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_wordline_ctrl_onehot_decoder.sv | 24 ++
 rtl/regfile_wordline_ctrl.sv | 119 +++++++++++
 tb/tb_regfile_wordline_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ==========================================================================
// regfile_pkg : shared types and constants for the register-file wordline ctrl
// Rev 1.0
// ==========================================================================
package regfile_pkg;

  localparam int DEFAULT_ADDR_W = 5;
  localparam int ZERO_REG       = 0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_wordline_ctrl_onehot_decoder.sv
`default_nettype none
// ==========================================================================
// onehot_decoder : combinational ADDR_W -> 2**ADDR_W enable decoder
// Rev 1.0
// ==========================================================================
module onehot_decoder
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   en,
  output logic [(1<<ADDR_W)-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule : onehot_decoder
`default_nettype wire

// File: rtl/regfile_wordline_ctrl.sv
`default_nettype none
// ==========================================================================
// regfile_wordline_ctrl : registered one-hot write wordline with clear sweep
// Rev 1.0
// ==========================================================================
module regfile_wordline_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W         = DEFAULT_ADDR_W,
  parameter bit ZERO_HARDWIRED = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic                   clr_req,
  output logic [(1<<ADDR_W)-1:0] wordline,
  output logic                   wdata_zero,
  output logic                   ready,
  output logic                   clr_done
);

  localparam int                N      = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(N - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic [N-1:0]        r_wordline;
  logic [N-1:0]        w_wordline_nxt;
  logic                r_wdata_zero;
  logic                r_ready;
  logic                r_clr_done;
  logic                w_wdata_zero_nxt;
  logic                w_ready_nxt;
  logic                w_clr_done_nxt;
  logic [ADDR_W-1:0]   w_dec_addr;
  logic                w_dec_en;
  logic                w_addr_is_zero;

  assign w_addr_is_zero = (wr_addr == ADDR_W'(ZERO_REG));

  onehot_decoder #(
    .ADDR_W (ADDR_W)
  ) u_dec (
    .addr   (w_dec_addr),
    .en     (w_dec_en),
    .onehot (w_wordline_nxt)
  );

  // Reset lands in CLEAR so the array is zeroed without any request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_CLEAR;
      r_cnt        <= '0;
      r_wordline   <= '0;
      r_wdata_zero <= 1'b0;
      r_ready      <= 1'b0;
      r_clr_done   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_wordline   <= w_wordline_nxt;
      r_wdata_zero <= w_wdata_zero_nxt;
      r_ready      <= w_ready_nxt;
      r_clr_done   <= w_clr_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_CLEAR: begin
        w_cnt_nxt = r_cnt + ADDR_W'(1);
        if (r_cnt == C_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        if (clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
    endcase
  end

  // The write on a clr_req edge still completes; the sweep starts next edge.
  always_comb begin
    w_dec_addr       = wr_addr;
    w_dec_en         = 1'b0;
    w_wdata_zero_nxt = 1'b0;
    w_ready_nxt      = 1'b0;
    w_clr_done_nxt   = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_dec_addr       = r_cnt;
        w_dec_en         = 1'b1;
        w_wdata_zero_nxt = 1'b1;
        w_ready_nxt      = (r_cnt == C_LAST);
        w_clr_done_nxt   = (r_cnt == C_LAST);
      end
      default: begin
        w_dec_en    = wr_en && !(ZERO_HARDWIRED && w_addr_is_zero);
        w_ready_nxt = !clr_req;
      end
    endcase
  end

  assign wordline   = r_wordline;
  assign wdata_zero = r_wdata_zero;
  assign ready      = r_ready;
  assign clr_done   = r_clr_done;

endmodule : regfile_wordline_ctrl
`default_nettype wire

// File: tb/tb_regfile_wordline_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_regfile_wordline_ctrl : three builds (5/ZH1, 5/ZH0, 3/ZH1) vs queue model
// Rev 1.0
// ==========================================================================
module tb_regfile_wordline_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic       clr_req = 1'b0;
  logic [4:0] wr_addr = '0;

  logic [31:0] wl_a, wl_b;
  logic [7:0]  wl_c;
  logic        wz [3];
  logic        rdy[3];
  logic        dn [3];
  logic [31:0] obs_wl[3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_wordline_ctrl #(.ADDR_W(5), .ZERO_HARDWIRED(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .clr_req(clr_req),
    .wordline(wl_a), .wdata_zero(wz[0]), .ready(rdy[0]), .clr_done(dn[0]));

  regfile_wordline_ctrl #(.ADDR_W(5), .ZERO_HARDWIRED(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .clr_req(clr_req),
    .wordline(wl_b), .wdata_zero(wz[1]), .ready(rdy[1]), .clr_done(dn[1]));

  regfile_wordline_ctrl #(.ADDR_W(3), .ZERO_HARDWIRED(1'b1)) u_dut_c (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr[2:0]), .clr_req(clr_req),
    .wordline(wl_c), .wdata_zero(wz[2]), .ready(rdy[2]), .clr_done(dn[2]));

  assign obs_wl[0] = wl_a;
  assign obs_wl[1] = wl_b;
  assign obs_wl[2] = {24'd0, wl_c};

  // Reference: a clear is a queue of pending indices to emit in order;
  // an empty queue means the controller accepts writes.
  int          aw[3] = '{5, 5, 3};
  bit          zh[3] = '{1'b1, 1'b0, 1'b1};
  int          pend[3][$];
  logic [31:0] e_wl[3];
  bit          e_wz[3], e_rdy[3], e_dn[3];

  task automatic model_fill(input int i);
    pend[i].delete();
    for (int k = 0; k < (1 << aw[i]); k++) pend[i].push_back(k);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      model_fill(i);
      e_wl[i] = '0; e_wz[i] = 0; e_rdy[i] = 0; e_dn[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int a;
    int k;
    a = int'(wr_addr) % (1 << aw[i]);
    if (pend[i].size() > 0) begin
      k        = pend[i].pop_front();
      e_wl[i]  = 32'd1 << k;
      e_wz[i]  = 1;
      e_dn[i]  = (pend[i].size() == 0);
      e_rdy[i] = e_dn[i];
    end else begin
      e_wz[i] = 0;
      e_dn[i] = 0;
      e_wl[i] = (wr_en && !(zh[i] && a == 0)) ? (32'd1 << a) : 32'd0;
      if (clr_req) begin
        model_fill(i);
        e_rdy[i] = 0;
      end else begin
        e_rdy[i] = 1;
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) model_step(i);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string ph);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("%s wordline[%0d]", ph, i), obs_wl[i], e_wl[i]);
      check_eq($sformatf("%s wdata_zero[%0d]", ph, i), {31'd0, wz[i]}, {31'd0, e_wz[i]});
      check_eq($sformatf("%s ready[%0d]", ph, i), {31'd0, rdy[i]}, {31'd0, e_rdy[i]});
      check_eq($sformatf("%s clr_done[%0d]", ph, i), {31'd0, dn[i]}, {31'd0, e_dn[i]});
      check_eq($sformatf("%s onehot[%0d]", ph, i), 32'($countones(obs_wl[i]) <= 1), 32'd1);
    end
  endtask

  task automatic step(input string ph, input bit we, input logic [4:0] a, input bit cr);
    wr_en = we; wr_addr = a; clr_req = cr;
    @(negedge clk);
    check_all(ph);
  endtask

  task automatic do_reset(input string ph);
    rst = 1'b1;
    #1;
    model_reset();
    check_all({ph, " async"});
    @(negedge clk);
    check_all({ph, " held"});
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset("por");
    for (int c = 0; c < 34; c++) step("sweep", 1'b0, 5'd0, 1'b0);

    step("wr7", 1'b1, 5'd7, 1'b0);
    step("wr0", 1'b1, 5'd0, 1'b0);
    step("idle", 1'b0, 5'd3, 1'b0);
    step("wr31clr", 1'b1, 5'd31, 1'b1);
    for (int c = 0; c < 34; c++) step("clr", 1'b0, 5'd0, 1'b0);

    step("clr2", 1'b0, 5'd0, 1'b1);
    for (int c = 0; c < 12; c++) step("clr2", 1'b0, 5'd0, 1'b0);
    do_reset("midrst");
    for (int c = 0; c < 6; c++) step("resweep", 1'b0, 5'd0, 1'b0);
    step("ignwr", 1'b1, 5'd5, 1'b0);
    step("ignclr", 1'b0, 5'd0, 1'b1);
    step("ignboth", 1'b1, 5'd5, 1'b1);
    for (int c = 0; c < 30; c++) step("resweep", 1'b0, 5'd0, 1'b0);

    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset("rndrst");
      end else begin
        step("rand", 1'($urandom), 5'($urandom), ($urandom_range(0, 24) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_regfile_wordline_ctrl
`default_nettype wire
